// File: rtl/pid_controller_sat.sv
// pid_controller_sat
// Three-stage pipelined PID controller. It has a saturating integrator,
// anti-windup and a clamped output.
//   stage 1 : error e = setpoint - process_variable, and capture of the
//             gains and bounds that travel with the sample
//   stage 2 : derivative d = e - prev_e, and the integrator update with
//             range saturation and anti-windup hold
//   stage 3 : kp*e + ki*integ + kd*d, floor shift by FRAC, then the clamp
// Ports
//   clk, reset                    single clock, synchronous active-high reset
//   in_valid                      the sample on the inputs is valid
//   setpoint, process_variable    signed DW-bit sample
//   kp, ki, kd                    signed GW-bit gains with FRAC fractional bits
//   out_min, out_max              signed DW-bit output clamp bounds
//   clear_int                     zero the integrator and the previous error
//   out_valid                     one-cycle pulse when control_output updates
//   control_output                clamped PID result
//   saturated                     the last output was clamped
//   int_clamped                   the last integrator update was held or clamped
module pid_controller_sat #(
    parameter int DW   = 16,
    parameter int GW   = 16,
    parameter int FRAC = 12,
    parameter int IW   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] setpoint,
    input  logic signed [DW-1:0] process_variable,
    input  logic signed [GW-1:0] kp,
    input  logic signed [GW-1:0] ki,
    input  logic signed [GW-1:0] kd,
    input  logic signed [DW-1:0] out_min,
    input  logic signed [DW-1:0] out_max,
    input  logic                 clear_int,
    output logic                 out_valid,
    output logic signed [DW-1:0] control_output,
    output logic                 saturated,
    output logic                 int_clamped
);

    localparam int EW  = DW + 1;          // error width
    localparam int DFW = DW + 2;          // derivative width
    localparam int SW  = IW + GW + 2;     // full-precision sum width

    localparam logic signed [IW-1:0] INTEG_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] INTEG_MIN = {1'b1, {(IW-1){1'b0}}};

    // stage 1 registers
    logic                 s1_valid;
    logic signed [EW-1:0] s1_e;
    logic signed [GW-1:0] s1_kp, s1_ki, s1_kd;
    logic signed [DW-1:0] s1_min, s1_max;

    // stage 2 registers and controller state
    logic                  s2_valid;
    logic signed [EW-1:0]  s2_e;
    logic signed [DFW-1:0] s2_d;
    logic signed [GW-1:0]  s2_kp, s2_ki, s2_kd;
    logic signed [DW-1:0]  s2_min, s2_max;
    logic signed [IW-1:0]  integ;
    logic signed [EW-1:0]  prev_e;

    // saturation direction of the most recent output, used for anti-windup
    logic sat_hi, sat_lo;

    // ---------------- stage 1 ----------------
    logic signed [EW-1:0] e_in;
    assign e_in = $signed({setpoint[DW-1], setpoint})
                - $signed({process_variable[DW-1], process_variable});

    // ---------------- stage 2 ----------------
    logic signed [EW-1:0]  prev_base;
    logic signed [IW-1:0]  integ_base;
    logic signed [DFW-1:0] d_next;
    logic signed [IW:0]    integ_sum;
    logic                  integ_ovf;
    logic                  integ_hold;
    logic signed [IW-1:0]  integ_next;

    always_comb begin
        // A clear that coincides with an update wins: the sample sees zero state.
        prev_base  = clear_int ? '0 : prev_e;
        integ_base = clear_int ? '0 : integ;
        d_next     = $signed({s1_e[EW-1], s1_e}) - $signed({prev_base[EW-1], prev_base});
        integ_sum  = $signed({integ_base[IW-1], integ_base})
                   + $signed({{(IW+1-EW){s1_e[EW-1]}}, s1_e});
        integ_ovf  = integ_sum[IW] != integ_sum[IW-1];
        // Do not push the integrator further in the direction the output is pinned.
        integ_hold = (sat_hi && !s1_e[EW-1] && (s1_e != '0)) || (sat_lo && s1_e[EW-1]);
        integ_next = integ_sum[IW-1:0];
        if (integ_hold)
            integ_next = integ_base;
        else if (integ_ovf)
            integ_next = integ_sum[IW] ? INTEG_MIN : INTEG_MAX;
    end

    // ---------------- stage 3 ----------------
    // The integ register holds the value written by the sample now in stage 2.
    // The next stage-2 write cannot take effect before this sample is registered.
    logic signed [SW-1:0] kp_x, ki_x, kd_x, e_x, i_x, d_x, min_x, max_x;
    logic signed [SW-1:0] sum, shifted;
    logic signed [DW-1:0] res_out;
    logic                 res_hi, res_lo;

    assign kp_x  = $signed({{(SW-GW){s2_kp[GW-1]}}, s2_kp});
    assign ki_x  = $signed({{(SW-GW){s2_ki[GW-1]}}, s2_ki});
    assign kd_x  = $signed({{(SW-GW){s2_kd[GW-1]}}, s2_kd});
    assign e_x   = $signed({{(SW-EW){s2_e[EW-1]}}, s2_e});
    assign i_x   = $signed({{(SW-IW){integ[IW-1]}}, integ});
    assign d_x   = $signed({{(SW-DFW){s2_d[DFW-1]}}, s2_d});
    assign min_x = $signed({{(SW-DW){s2_min[DW-1]}}, s2_min});
    assign max_x = $signed({{(SW-DW){s2_max[DW-1]}}, s2_max});

    assign sum     = kp_x * e_x + ki_x * i_x + kd_x * d_x;
    assign shifted = sum >>> FRAC;   // arithmetic shift floors toward -inf

    always_comb begin
        res_out = shifted[DW-1:0];
        res_hi  = 1'b0;
        res_lo  = 1'b0;
        if (min_x > max_x) begin
            // Inverted bounds: out_min wins, and the direction is taken relative to it.
            res_out = s2_min;
            res_hi  = shifted > min_x;
            res_lo  = shifted < min_x;
        end else if (shifted > max_x) begin
            res_out = s2_max;
            res_hi  = 1'b1;
        end else if (shifted < min_x) begin
            res_out = s2_min;
            res_lo  = 1'b1;
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            out_valid      <= 1'b0;
            integ          <= '0;
            prev_e         <= '0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
            control_output <= '0;
            saturated      <= 1'b0;
            int_clamped    <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s1_valid) begin
                integ       <= integ_next;
                prev_e      <= s1_e;
                int_clamped <= integ_hold | integ_ovf;
            end else if (clear_int) begin
                integ  <= '0;
                prev_e <= '0;
            end
            if (s2_valid) begin
                control_output <= res_out;
                saturated      <= res_hi | res_lo;
                sat_hi         <= res_hi;
                sat_lo         <= res_lo;
            end
        end
    end

    // ---------------- datapath registers (qualified by valid) ----------------
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_e   <= e_in;
            s1_kp  <= kp;
            s1_ki  <= ki;
            s1_kd  <= kd;
            s1_min <= out_min;
            s1_max <= out_max;
        end
        if (s1_valid) begin
            s2_e   <= s1_e;
            s2_d   <= d_next;
            s2_kp  <= s1_kp;
            s2_ki  <= s1_ki;
            s2_kd  <= s1_kd;
            s2_min <= s1_min;
            s2_max <= s1_max;
        end
    end

endmodule

// File: tb/tb_pid_controller_sat.sv
// tb_pid_controller_sat
// Self-checking bench for pid_controller_sat. It applies three kinds of stimulus:
// a table of isolated samples, hand-written multi-cycle sequences, and a
// randomized stream checked against a sample-level PID reference model.
// Ports: none (top-level bench).
module tb_pid_controller_sat;

    localparam int DW   = 16;
    localparam int GW   = 16;
    localparam int FRAC = 12;
    localparam int IW   = 24;
    localparam int NV   = 13;
    localparam int NRND = 400;
    localparam int NR   = NRND + 3;
    localparam longint IMAX = (longint'(1) << (IW - 1)) - 1;
    localparam longint IMIN = -(longint'(1) << (IW - 1));

    logic clk = 1'b0;
    logic reset, in_valid, clear_int;
    logic signed [DW-1:0] setpoint, process_variable, out_min, out_max;
    logic signed [GW-1:0] kp, ki, kd;
    logic out_valid, saturated, int_clamped;
    logic signed [DW-1:0] control_output;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pid_controller_sat #(.DW(DW), .GW(GW), .FRAC(FRAC), .IW(IW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .setpoint(setpoint), .process_variable(process_variable),
        .kp(kp), .ki(ki), .kd(kd),
        .out_min(out_min), .out_max(out_max), .clear_int(clear_int),
        .out_valid(out_valid), .control_output(control_output),
        .saturated(saturated), .int_clamped(int_clamped)
    );

    typedef struct {
        string name;
        int    sp, pv, gp, gi, gd, mn, mx;
        bit    clr;
        int    exp_out;
        bit    exp_sat, exp_ic;
    } vec_t;

    vec_t vecs [NV];

    // random stimulus and expected values per cycle
    int     r_sp [NR], r_pv [NR], r_kp [NR], r_ki [NR], r_kd [NR], r_mn [NR], r_mx [NR];
    bit     r_v [NR], r_clr [NR];
    longint m_e [NR], m_d [NR], m_i [NR];
    bit     x_ov [NR], x_sat [NR], x_ic [NR];
    longint x_out [NR];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sp, input int pv, input int gp, input int gi, input int gd,
                         input int mn, input int mx, input bit v, input bit clr);
        setpoint         = DW'(sp);
        process_variable = DW'(pv);
        kp               = GW'(gp);
        ki               = GW'(gi);
        kd               = GW'(gd);
        out_min          = DW'(mn);
        out_max          = DW'(mx);
        in_valid         = v;
        clear_int        = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit clr);
        in_valid  = 1'b0;
        clear_int = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input bit ov, input longint o,
                                 input bit s, input bit ic);
        check({name, "_ov"},  out_valid, ov);
        check({name, "_out"}, control_output, o);
        check({name, "_sat"}, saturated, s);
        check({name, "_ic"},  int_clamped, ic);
    endtask

    // floor(s / 2^FRAC)
    function automatic longint floor_div(input longint s);
        longint q;
        q = s / (longint'(1) << FRAC);
        if ((s % (longint'(1) << FRAC)) != 0 && s < 0)
            q = q - 1;
        return q;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint mi, mp, mo, e, base, pb, s, r, mn, mx;
        bit     mhi, mlo, msat, mic, hold, ovf;
        int     t;

        vecs[0]  = '{"prop",      100,  40, 4096,    0,    0, -32767, 32767, 1'b1,   60, 1'b0, 1'b0};
        vecs[1]  = '{"int1",        5,   0,    0, 4096,    0, -32767, 32767, 1'b1,    5, 1'b0, 1'b0};
        vecs[2]  = '{"int2",        5,   0,    0, 4096,    0, -32767, 32767, 1'b0,   10, 1'b0, 1'b0};
        vecs[3]  = '{"int3",        5,   0,    0, 4096,    0, -32767, 32767, 1'b0,   15, 1'b0, 1'b0};
        vecs[4]  = '{"int4",        5,   0,    0, 4096,    0, -32767, 32767, 1'b0,   20, 1'b0, 1'b0};
        vecs[5]  = '{"int_clr",     5,   0,    0, 4096,    0, -32767, 32767, 1'b1,    5, 1'b0, 1'b0};
        vecs[6]  = '{"sat_hi1",  1000,   0, 4096, 4096,    0, -32767,   500, 1'b1,  500, 1'b1, 1'b0};
        vecs[7]  = '{"sat_hi2",  1000,   0, 4096, 4096,    0, -32767,   500, 1'b0,  500, 1'b1, 1'b1};
        vecs[8]  = '{"int_held",    0,   0,    0, 4096,    0, -32767, 32767, 1'b0, 1000, 1'b0, 1'b0};
        vecs[9]  = '{"floor",      -3,   0, 2048,    0,    0, -32767, 32767, 1'b1,   -2, 1'b0, 1'b0};
        vecs[10] = '{"inverted",   30,   0, 4096,    0,    0,     10,   -10, 1'b1,   10, 1'b1, 1'b0};
        vecs[11] = '{"sat_lo1",  -200,   0, 4096,    0,    0,   -100,   100, 1'b1, -100, 1'b1, 1'b0};
        vecs[12] = '{"sat_lo2",  -200,   0, 4096,    0,    0,   -100,   100, 1'b0, -100, 1'b1, 1'b1};

        // ---- reset state ----
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        check_outputs("reset", 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(1'b0);

        // ---- table of isolated samples ----
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sp, vecs[i].pv, vecs[i].gp, vecs[i].gi, vecs[i].gd,
                  vecs[i].mn, vecs[i].mx, 1'b1, vecs[i].clr);
            idle(1'b0);
            check({vecs[i].name, "_early_ov"}, out_valid, 0);
            idle(1'b0);
            check_outputs(vecs[i].name, 1'b1, vecs[i].exp_out, vecs[i].exp_sat, vecs[i].exp_ic);
            idle(1'b0);
            check({vecs[i].name, "_pulse"}, out_valid, 0);
            check({vecs[i].name, "_hold"}, control_output, vecs[i].exp_out);
        end

        // ---- derivative on consecutive samples ----
        idle(1'b1);
        drive(10, 0, 0, 0, 4096, -32767, 32767, 1'b1, 1'b0);
        drive(30, 0, 0, 0, 4096, -32767, 32767, 1'b1, 1'b0);
        idle(1'b0);
        check("deriv1_ov", out_valid, 1);
        check("deriv1_out", control_output, 10);
        idle(1'b0);
        check("deriv2_ov", out_valid, 1);
        check("deriv2_out", control_output, 20);
        idle(1'b0);
        check("deriv_end_ov", out_valid, 0);

        // ---- clear_int while the sample is in stage 2: d=e and integ=e ----
        drive(5, 0, 0, 4096, 4096, -32767, 32767, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check("clr_s2_out", control_output, 10);
        drive(5, 0, 0, 4096, 4096, -32767, 32767, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("clr_s2_next_out", control_output, 10);

        // ---- reset mid-operation ----
        drive(50, 0, 4096, 0, 0, -32767, 32767, 1'b1, 1'b0);
        drive(50, 0, 4096, 0, 0, -32767, 32767, 1'b1, 1'b0);
        reset = 1'b1;
        drive(99, 0, 4096, 0, 0, -32767, 32767, 1'b1, 1'b1);
        reset = 1'b0;
        check_outputs("rst_mid", 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check($sformatf("rst_flush%0d_ov", i), out_valid, 0);
        end
        drive(7, 0, 0, 0, 4096, -32767, 32767, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("rst_post_ov", out_valid, 1);
        check("rst_post_out", control_output, 7);

        // ---- randomized stream vs. reference model ----
        for (int c = 0; c < NR; c++) begin
            r_v[c]  = (c < NRND) && ($urandom_range(0, 9) < 7);
            r_sp[c] = int'($urandom_range(0, 4000)) - 2000;
            r_pv[c] = int'($urandom_range(0, 4000)) - 2000;
            r_kp[c] = int'($urandom_range(0, 16384)) - 8192;
            r_ki[c] = int'($urandom_range(0, 16384)) - 8192;
            r_kd[c] = int'($urandom_range(0, 16384)) - 8192;
            if ($urandom_range(0, 9) == 0) begin
                r_mn[c] = int'($urandom_range(0, 500));
                r_mx[c] = -int'($urandom_range(0, 500));
            end else begin
                r_mn[c] = -int'($urandom_range(0, 3000));
                r_mx[c] = int'($urandom_range(0, 3000));
            end
            r_clr[c] = (c < NRND) && (c == 0 || !r_v[c-1]) && ($urandom_range(0, 19) == 0);
        end

        // Reference model, walked edge by edge. At each edge the stage-2 update
        // sees the saturation from outputs that were already registered, and
        // then the output of the sample two cycles older is registered.
        mi = 0; mp = 0; mo = 0; mhi = 0; mlo = 0; msat = 0; mic = 0;
        for (int c = 0; c < NR; c++) begin
            if (c >= 1 && r_v[c-1]) begin
                t    = c - 1;
                e    = longint'(r_sp[t]) - longint'(r_pv[t]);
                base = r_clr[c] ? 0 : mi;
                pb   = r_clr[c] ? 0 : mp;
                s    = base + e;
                ovf  = (s > IMAX) || (s < IMIN);
                hold = (mhi && e > 0) || (mlo && e < 0);
                if (hold)          mi = base;
                else if (s > IMAX) mi = IMAX;
                else if (s < IMIN) mi = IMIN;
                else               mi = s;
                mic    = hold || ovf;
                mp     = e;
                m_e[t] = e;
                m_d[t] = e - pb;
                m_i[t] = mi;
            end else if (r_clr[c]) begin
                mi = 0;
                mp = 0;
            end
            if (c >= 2 && r_v[c-2]) begin
                t  = c - 2;
                s  = longint'(r_kp[t]) * m_e[t] + longint'(r_ki[t]) * m_i[t]
                   + longint'(r_kd[t]) * m_d[t];
                r  = floor_div(s);
                mn = r_mn[t];
                mx = r_mx[t];
                mhi = 0;
                mlo = 0;
                if (mn > mx) begin
                    mo  = mn;
                    mhi = r > mn;
                    mlo = r < mn;
                end else if (r > mx) begin
                    mo  = mx;
                    mhi = 1;
                end else if (r < mn) begin
                    mo  = mn;
                    mlo = 1;
                end else begin
                    mo = r;
                end
                msat = mhi || mlo;
            end
            x_ov[c]  = (c >= 2) && r_v[c-2];
            x_out[c] = mo;
            x_sat[c] = msat;
            x_ic[c]  = mic;
        end

        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        reset = 1'b0;
        for (int c = 0; c < NR; c++) begin
            drive(r_sp[c], r_pv[c], r_kp[c], r_ki[c], r_kd[c], r_mn[c], r_mx[c], r_v[c], r_clr[c]);
            check_outputs($sformatf("rand@%0d", c), x_ov[c], x_out[c], x_sat[c], x_ic[c]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_controller_sat.md
PID_CONTROLLER_SAT -- requirements
Module: pid_controller_sat

Interface
REQ-001 The block SHALL have parameter DW, default 16: signed data width of setpoint, process variable, bounds and output.
REQ-002 The block SHALL have parameter GW, default 16: signed gain width.
REQ-003 The block SHALL have parameter FRAC, default 12: number of fractional bits in each gain.
REQ-004 The block SHALL have parameter IW, default 24: signed integrator width, with IW > DW.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the current sample is valid.
REQ-008 The block SHALL have ports setpoint and process_variable, input, DW bits each, signed.
REQ-009 The block SHALL have ports kp, ki and kd, input, GW bits each, signed: gains with FRAC fractional bits, captured together with the sample.
REQ-010 The block SHALL have ports out_min and out_max, input, DW bits each, signed: output clamp bounds, captured together with the sample.
REQ-011 The block SHALL have port clear_int, input, 1 bit: clears the integrator and the previous-error state.
REQ-012 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse when control_output is updated.
REQ-013 The block SHALL have port control_output, output, DW bits, signed: the clamped PID result.
REQ-014 The block SHALL have port saturated, output, 1 bit: the last output was clamped.
REQ-015 The block SHALL have port int_clamped, output, 1 bit: the last integrator update was held or clamped.

Function
REQ-016 Pipeline SHALL be three stages: a sample with in_valid high at edge T produces out_valid high for exactly one cycle after edge T+2, i.e. latency 3 cycles.
REQ-017 Throughput SHALL be one sample per cycle; back-to-back samples SHALL NOT stall or be dropped; there is no backpressure.
REQ-018 Stage 1 SHALL register e = setpoint - process_variable at DW+1 bits, together with the gains, bounds and a valid bit.
REQ-019 Stage 2, for a valid entry only, SHALL compute:
- d = e - prev_e at DW+2 bits;
- prev_e <= e;
- integ <= integ + e, saturated to the signed IW range.
REQ-020 Anti-windup: stage 2 SHALL hold integ unchanged when the last output saturated high and e > 0, or saturated low and e < 0.
REQ-021 int_clamped SHALL update on each valid stage-2 entry: 1 if the integrator was held (REQ-020) or range-saturated, else 0.
REQ-022 Stage 3 SHALL compute sum = kp*e + ki*integ + kd*d with full-precision products at IW+GW+2 bits, with no internal overflow.
REQ-023 Stage 3 SHALL then arithmetically shift sum right by FRAC, truncating toward negative infinity.
REQ-024 Stage 3 SHALL then clamp: result > out_max gives out_max; otherwise result < out_min gives out_min; otherwise the result unchanged.
REQ-025 If out_min > out_max, control_output SHALL equal out_min.
REQ-026 saturated SHALL be 1 when the clamp changed the value; a 2-bit high/low saturation state SHALL be kept internally for REQ-020.
REQ-027 control_output, saturated and int_clamped SHALL hold their values between valid outputs.
REQ-028 Bubbles (in_valid=0) SHALL NOT alter integ, prev_e or the outputs.
REQ-029 clear_int SHALL zero integ and prev_e at the next edge.
REQ-030 clear_int SHALL take priority over a simultaneous stage-2 update; that sample SHALL then use integ=0 and prev_e=0, so d=e and the new integ=e.
REQ-031 Samples already in stage 1 or stage 3 SHALL complete normally when clear_int is asserted.

Reset
REQ-032 While reset is high at an edge, all of the following SHALL be cleared to 0: every valid bit, integ, prev_e, internal saturation state, control_output, saturated, int_clamped and out_valid.
REQ-033 reset SHALL take priority over in_valid and clear_int.
REQ-034 In-flight samples SHALL be discarded on reset, and no out_valid SHALL follow from them.

Verification
REQ-035 The bench SHALL cover proportional: sp=100, pv=40, kp=0x1000, ki=kd=0, bounds ±32767 -> control_output=60 with out_valid 3 cycles later and saturated=0.
REQ-036 The bench SHALL cover derivative: kd=0x1000, others 0, e=10 then e=30 on consecutive cycles -> outputs 10 then 20 on consecutive cycles.
REQ-037 The bench SHALL cover integral and clear: ki=0x1000, e=5 for four samples -> outputs 5, 10, 15, 20; then clear_int with the next sample e=5 -> output 5.
REQ-038 The bench SHALL cover saturation and anti-windup: kp=ki=0x1000, out_max=500, e=1000 -> output 500 with saturated=1; the second such sample gives int_clamped=1 and integ held at 1000.
REQ-039 The bench SHALL cover bounds inverted: out_min=10, out_max=-10, any sample -> control_output=10.
REQ-040 The bench SHALL cover reset mid-operation: in_valid on two cycles, then reset on the next edge -> no out_valid, all outputs 0, and the first post-reset sample behaves as if prev_e=0.
